step_speed_ramp_ctrl: RTL and testbench

Sequences the motor step-clock generator. It accepts speed/direction commands and ramps the generator's `real_speed` input up or down in fixed steps at a fixed interval, toward the commanded target. On a direction reversal it decelerates to zero, holds a dwell, and only then flips direction. It gates the generator with `motor_en` so the generator never sees a zero speed while enabled.

---
 rtl/step_speed_ramp_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_step_speed_ramp_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/step_speed_ramp_ctrl.sv
// step_speed_ramp_ctrl
//
// Sequences the motor step-clock generator. It takes speed/direction commands
// and ramps real_speed toward the commanded target. Each ramp tick changes the
// speed by ACCEL_STEP, and ticks come every RAMP_INTERVAL clocks. A direction
// reversal works in three phases: the motor decelerates to zero, waits
// DIR_HOLD clocks, and only then flips motor_dir. motor_en is high exactly
// when real_speed is nonzero, so the generator never runs enabled at zero speed.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is low while reset is asserted, while stop is high, and in DWELL.
// An accepted command replaces the target immediately, even mid-ramp. The FSM
// acts on the new target from the following cycle. stop forces the target to
// zero every cycle it is high, and it blocks a simultaneous command.
//
// Ports:
//   clk         chip clock, rising edge
//   rst         synchronous reset, active low
//   cmd_valid   command present
//   cmd_ready   command can be accepted this cycle
//   cmd_speed   target speed (rotations/s, unsigned, clamped to MAX_SPEED)
//   cmd_dir     target direction
//   stop        level: ramp to zero and idle
//   real_speed  speed to the step-clock generator
//   motor_dir   direction to the driver (changes only at zero speed)
//   motor_en    high iff real_speed != 0
//   at_speed    high in CRUISE
//   busy        high in ACCEL, DECEL, DWELL
//   state_dbg   current FSM state encoding (debug)
module step_speed_ramp_ctrl #(
  parameter int unsigned ACCEL_STEP    = 1,
  parameter int unsigned RAMP_INTERVAL = 20_000,
  parameter int unsigned MAX_SPEED     = 50,
  parameter int unsigned DIR_HOLD      = 20_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_speed,
  input  logic        cmd_dir,
  input  logic        stop,
  output logic [31:0] real_speed,
  output logic        motor_dir,
  output logic        motor_en,
  output logic        at_speed,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_DECEL  = 3'd2,
    S_CRUISE = 3'd3,
    S_DWELL  = 3'd4
  } state_t;

  localparam logic [31:0] STEP    = 32'(ACCEL_STEP);
  localparam logic [31:0] RI_LAST = 32'(RAMP_INTERVAL - 1);
  localparam logic [31:0] DH_LAST = 32'(DIR_HOLD - 1);
  localparam logic [31:0] MAX     = 32'(MAX_SPEED);

  state_t      state, state_nxt;
  logic [31:0] tgt;
  logic        tgt_dir;
  logic [31:0] ramp_cnt, ramp_nxt;
  logic [31:0] dwell_cnt, dwell_nxt;
  logic [31:0] speed_nxt;
  logic        dir_nxt;

  logic        accept;
  logic        tick;
  logic [31:0] clamp;
  logic [31:0] eff;
  logic [31:0] gap_up, gap_dn;
  logic [31:0] up_val, dn_val;

  assign cmd_ready = rst && !stop && (state != S_DWELL);
  assign accept    = cmd_valid && cmd_ready;
  assign clamp     = (cmd_speed > MAX) ? MAX : cmd_speed;
  assign tick      = (ramp_cnt == RI_LAST);
  assign state_dbg = state;

  // While moving in the wrong direction the only legal target is zero.
  assign eff = ((tgt_dir != motor_dir) && (real_speed != '0)) ? '0 : tgt;

  // The gaps are only used when eff is on the matching side of real_speed.
  // The min() makes the last step a partial one, so the speed never overshoots eff.
  assign gap_up = eff - real_speed;
  assign gap_dn = real_speed - eff;
  assign up_val = real_speed + ((gap_up < STEP) ? gap_up : STEP);
  assign dn_val = real_speed - ((gap_dn < STEP) ? gap_dn : STEP);

  always_comb begin
    state_nxt = state;
    speed_nxt = real_speed;
    dir_nxt   = motor_dir;
    ramp_nxt  = '0;
    dwell_nxt = '0;
    case (state)
      S_IDLE: begin
        // The motor is at rest, so a new direction can take effect without a dwell.
        if (accept && (clamp != '0)) begin
          dir_nxt   = cmd_dir;
          state_nxt = S_ACCEL;
        end
      end
      S_ACCEL: begin
        if (eff < real_speed) begin
          state_nxt = S_DECEL;
        end else if (tick) begin
          speed_nxt = up_val;
          // A zero target reached from rest (e.g. stop right after accept)
          // goes back to IDLE rather than cruising at zero.
          if (up_val == eff) state_nxt = (eff == '0) ? S_IDLE : S_CRUISE;
        end else begin
          ramp_nxt = ramp_cnt + 32'd1;
        end
      end
      S_DECEL: begin
        if (eff > real_speed) begin
          state_nxt = S_ACCEL;
        end else if (tick) begin
          speed_nxt = dn_val;
          if (dn_val == eff) begin
            if (dn_val != '0)                              state_nxt = S_CRUISE;
            else if ((tgt_dir != motor_dir) && (tgt != '0)) state_nxt = S_DWELL;
            else                                           state_nxt = S_IDLE;
          end
        end else begin
          ramp_nxt = ramp_cnt + 32'd1;
        end
      end
      S_CRUISE: begin
        if (eff > real_speed)      state_nxt = S_ACCEL;
        else if (eff < real_speed) state_nxt = S_DECEL;
      end
      S_DWELL: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (dwell_cnt == DH_LAST) begin
          dir_nxt   = tgt_dir;
          state_nxt = S_ACCEL;
        end else begin
          dwell_nxt = dwell_cnt + 32'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      tgt        <= '0;
      tgt_dir    <= 1'b0;
      ramp_cnt   <= '0;
      dwell_cnt  <= '0;
      real_speed <= '0;
      motor_dir  <= 1'b0;
      motor_en   <= 1'b0;
      at_speed   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (stop) begin
        tgt <= '0;
      end else if (accept) begin
        tgt     <= clamp;
        tgt_dir <= cmd_dir;
      end
      state      <= state_nxt;
      ramp_cnt   <= ramp_nxt;
      dwell_cnt  <= dwell_nxt;
      real_speed <= speed_nxt;
      motor_dir  <= dir_nxt;
      motor_en   <= (speed_nxt != '0);
      at_speed   <= (state_nxt == S_CRUISE);
      busy       <= (state_nxt == S_ACCEL) || (state_nxt == S_DECEL) ||
                    (state_nxt == S_DWELL);
    end
  end

endmodule

// File: tb/tb_step_speed_ramp_ctrl.sv
module tb_step_speed_ramp_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEL  = 3'd1;
  localparam logic [2:0] ST_DECEL  = 3'd2;
  localparam logic [2:0] ST_CRUISE = 3'd3;
  localparam logic [2:0] ST_DWELL  = 3'd4;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_speed = '0;
  logic        cmd_dir = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] real_speed;
  logic        motor_dir;
  logic        motor_en;
  logic        at_speed;
  logic        busy;
  logic [2:0]  state_dbg;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  step_speed_ramp_ctrl #(
    .ACCEL_STEP(2), .RAMP_INTERVAL(4), .MAX_SPEED(10), .DIR_HOLD(3)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_speed(cmd_speed), .cmd_dir(cmd_dir), .stop(stop),
    .real_speed(real_speed), .motor_dir(motor_dir), .motor_en(motor_en),
    .at_speed(at_speed), .busy(busy), .state_dbg(state_dbg)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_speed = '0; cmd_dir = 1'b0; stop = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  // Presents one command for a single edge; returns 1 time unit after that edge.
  task automatic send(input logic [31:0] spd, input logic dir);
    cmd_valid = 1'b1; cmd_speed = spd; cmd_dir = dir;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; stop = 1'b0;
    step(2);
    checks++; if ({real_speed, motor_dir, motor_en, at_speed, busy} !== 36'd0) $display("FAIL reset_outputs: got %h want 0", {real_speed, motor_dir, motor_en, at_speed, busy}); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else passed++;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", cmd_ready); else passed++;
    // zero-speed command stays idle
    send(32'd0, 1'b1);
    step(1);
    checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0 || motor_dir !== 1'b0) $display("FAIL zero_cmd_idle: got st=%0d busy=%b dir=%b want st=0 busy=0 dir=0", state_dbg, busy, motor_dir); else passed++;
  endtask

  task automatic test_basic_ramp();
    do_reset();
    send(32'd6, 1'b0);
    checks++; if (state_dbg !== ST_ACCEL || busy !== 1'b1 || real_speed !== 32'd0) $display("FAIL s1_enter_accel: got st=%0d busy=%b spd=%0d want st=1 busy=1 spd=0", state_dbg, busy, real_speed); else passed++;
    step(3);
    checks++; if (real_speed !== 32'd0 || motor_en !== 1'b0) $display("FAIL s1_before_tick: got spd=%0d en=%b want 0 0", real_speed, motor_en); else passed++;
    step(1);
    checks++; if (real_speed !== 32'd2 || motor_en !== 1'b1) $display("FAIL s1_first_step: got spd=%0d en=%b want 2 1", real_speed, motor_en); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd4 || at_speed !== 1'b0) $display("FAIL s1_second_step: got spd=%0d at=%b want 4 0", real_speed, at_speed); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd6 || at_speed !== 1'b1 || busy !== 1'b0) $display("FAIL s1_cruise: got spd=%0d at=%b busy=%b want 6 1 0", real_speed, at_speed, busy); else passed++;
  endtask

  task automatic test_clamp();
    logic [31:0] exp_spd;
    do_reset();
    send(32'd15, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(4);
      exp_spd = 32'(2 * i);
      checks++; if (real_speed !== exp_spd) $display("FAIL s2_step%0d: got %0d want %0d", i, real_speed, exp_spd); else passed++;
    end
    checks++; if (state_dbg !== ST_CRUISE || at_speed !== 1'b1) $display("FAIL s2_cruise: got st=%0d at=%b want 3 1", state_dbg, at_speed); else passed++;
    step(8);
    checks++; if (real_speed !== 32'd10 || state_dbg !== ST_CRUISE) $display("FAIL s2_hold: got spd=%0d st=%0d want 10 3", real_speed, state_dbg); else passed++;
  endtask

  task automatic test_partial_step();
    do_reset();
    send(32'd6, 1'b0);
    step(12);
    send(32'd7, 1'b0);
    step(1);
    checks++; if (state_dbg !== ST_ACCEL || busy !== 1'b1) $display("FAIL s3_reaccel: got st=%0d busy=%b want 1 1", state_dbg, busy); else passed++;
    step(3);
    checks++; if (real_speed !== 32'd6) $display("FAIL s3_pre_step: got %0d want 6", real_speed); else passed++;
    step(1);
    checks++; if (real_speed !== 32'd7 || at_speed !== 1'b1) $display("FAIL s3_partial: got spd=%0d at=%b want 7 1", real_speed, at_speed); else passed++;
  endtask

  task automatic test_reversal();
    do_reset();
    send(32'd6, 1'b0);
    step(12);
    send(32'd4, 1'b1);
    step(1);
    checks++; if (state_dbg !== ST_DECEL) $display("FAIL s4_decel: got %0d want %0d", state_dbg, ST_DECEL); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd4) $display("FAIL s4_dn4: got %0d want 4", real_speed); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd2) $display("FAIL s4_dn2: got %0d want 2", real_speed); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd0 || motor_en !== 1'b0 || state_dbg !== ST_DWELL || cmd_ready !== 1'b0) $display("FAIL s4_dwell_entry: got spd=%0d en=%b st=%0d rdy=%b want 0 0 4 0", real_speed, motor_en, state_dbg, cmd_ready); else passed++;
    step(2);
    checks++; if (state_dbg !== ST_DWELL || motor_dir !== 1'b0 || busy !== 1'b1) $display("FAIL s4_dwell_hold: got st=%0d dir=%b busy=%b want 4 0 1", state_dbg, motor_dir, busy); else passed++;
    step(1);
    checks++; if (state_dbg !== ST_ACCEL || motor_dir !== 1'b1 || real_speed !== 32'd0) $display("FAIL s4_flip: got st=%0d dir=%b spd=%0d want 1 1 0", state_dbg, motor_dir, real_speed); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd2) $display("FAIL s4_up2: got %0d want 2", real_speed); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd4 || at_speed !== 1'b1) $display("FAIL s4_cruise: got spd=%0d at=%b want 4 1", real_speed, at_speed); else passed++;
  endtask

  task automatic test_stop();
    do_reset();
    send(32'd10, 1'b0);
    step(8);
    checks++; if (real_speed !== 32'd4) $display("FAIL s5_at4: got %0d want 4", real_speed); else passed++;
    stop = 1'b1; cmd_valid = 1'b1; cmd_speed = 32'd10;
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL s5_ready_stop: got %b want 0", cmd_ready); else passed++;
    step(1);
    cmd_valid = 1'b0;
    step(1);
    checks++; if (state_dbg !== ST_DECEL) $display("FAIL s5_decel: got %0d want %0d", state_dbg, ST_DECEL); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd2) $display("FAIL s5_dn2: got %0d want 2", real_speed); else passed++;
    step(4);
    checks++; if (real_speed !== 32'd0 || busy !== 1'b0 || motor_en !== 1'b0 || state_dbg !== ST_IDLE) $display("FAIL s5_idle: got spd=%0d busy=%b en=%b st=%0d want 0 0 0 0", real_speed, busy, motor_en, state_dbg); else passed++;
    stop = 1'b0;
    step(6);
    checks++; if (state_dbg !== ST_IDLE || real_speed !== 32'd0) $display("FAIL s5_stays_idle: got st=%0d spd=%0d want 0 0", state_dbg, real_speed); else passed++;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    send(32'd10, 1'b1);
    step(8);
    checks++; if (real_speed !== 32'd4 || motor_dir !== 1'b1) $display("FAIL s6_at4: got spd=%0d dir=%b want 4 1", real_speed, motor_dir); else passed++;
    rst = 1'b0;
    step(1);
    checks++; if ({real_speed, motor_dir, motor_en, at_speed, busy} !== 36'd0 || state_dbg !== ST_IDLE) $display("FAIL s6_reset: got %h st=%0d want 0 0", {real_speed, motor_dir, motor_en, at_speed, busy}, state_dbg); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL s6_ready_low: got %b want 0", cmd_ready); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL s6_ready_high: got %b want 1", cmd_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_clamp();
    test_partial_step();
    test_reversal();
    test_stop();
    test_reset_mid_ramp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
